prf_writeback_buffer: RTL and testbench
=======================================

Name: prf_writeback_buffer

Overview:
- Sits directly upstream of the physical register file (PRF) write ports.
- Collects results from NUM_SRC functional-unit writeback lanes and holds them in a circular queue.
- Drains up to NUM_WR results per cycle into the PRF write ports, oldest first.
- Lets more producers share fewer PRF write ports without losing results.

Parameters:
- NUM_SRC, 4: producer lanes.
- NUM_WR, 2: PRF write ports driven. Must satisfy NUM_WR <= NUM_SRC.
- DEPTH, 8: queue entries. Power of 2, and DEPTH >= NUM_SRC.
- INDEX, 7: physical register index width.
- WIDTH, 64: data width.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous active-low reset.
- src_valid_i, input, NUM_SRC: per-lane result valid.
- src_addr_i, input, NUM_SRC*INDEX: per-lane destination physical register. Lane k occupies bits [k*INDEX +: INDEX].
- src_data_i, input, NUM_SRC*WIDTH: per-lane result data. Same packing as src_addr_i.
- src_ready_o, output, 1: common accept signal for all lanes.
- wr_we_o, output, NUM_WR: PRF write enables.
- wr_addr_o, output, NUM_WR*INDEX: PRF write addresses.
- wr_data_o, output, NUM_WR*WIDTH: PRF write data.
- count_o, output, $clog2(DEPTH+1): current occupancy.
- empty_o, output, 1: count_o == 0.
- full_o, output, 1: count_o == DEPTH.

Behaviour:
- Reset (async, reset_n low):
  - head, tail and count go to 0, so wr_we_o = 0, empty_o = 1, full_o = 0 immediately.
  - src_ready_o = 1 immediately.
  - Storage array is not reset.
  - Reset mid-operation discards all queued results.
- Ready rule:
  - src_ready_o = (DEPTH - count) >= NUM_SRC, using the registered count.
  - Same-cycle drain is not credited, so overflow is impossible by construction.
- Accept:
  - Lane k's result is accepted on a cycle with src_valid_i[k] && src_ready_o.
  - When src_ready_o = 0, valids are ignored. Producers hold the result and retry.
- Enqueue order:
  - Accepted lanes are compacted in ascending lane index.
  - They are written to slots tail, tail+1, ... modulo DEPTH.
  - tail advances by the number of accepted lanes (popcount). Pointers wrap modulo DEPTH.
- Drain:
  - n = min(count, NUM_WR) entries are drained each cycle, unconditionally; the PRF never stalls.
  - Port j (j < n) drives entry head+j with wr_we_o[j] = 1. Ports j >= n have wr_we_o[j] = 0.
  - Address and data on disabled ports are don't-care.
  - head advances by n.
- Outputs:
  - wr_* are combinational from registered head entries.
  - Latency is exactly 1 cycle from accept to PRF write when the queue is empty (bypass disabled).
- Occupancy: count_next = count + accepted - drained, with enqueue and drain in the same cycle allowed.
- Ordering: results leave in global accept order, i.e. by cycle, then by lane index. Duplicate destination addresses are written in that order.
- Boundaries:
  - count == DEPTH: full_o = 1, src_ready_o = 0, and drain proceeds.
  - No valid lanes: nothing is enqueued.
  - Wrap-around of head or tail across slot DEPTH-1 to slot 0 must be seamless.

Optional Feature:
- Macro: PRF_WB_BYPASS_EN.
- Defined:
  - When registered count == 0 and src_ready_o = 1, the first min(popcount(valid), NUM_WR) accepted lanes, in ascending index, drive wr_* in the same cycle.
  - Remaining accepted lanes are enqueued.
  - Drain from the queue is 0 that cycle, since it is empty.
  - Zero-latency path.
- Undefined:
  - All results pass through the queue, giving a 1-cycle minimum latency.
  - No combinational path from src_* to wr_*.

Decomposition:
- Shared package prf_wb_pkg holds:
  - Default parameter constants.
  - A function computing the occupancy width, $clog2(DEPTH+1).
- Entry storage is two arrays, addr and data, sized by module parameters; no packed-struct typedef, because the widths are parameterised.
- One natural sub-module: prf_wb_compact.
  - Prefix-sum over src_valid_i.
  - Produces each lane's slot offset and the accepted count.
  - Reused by the bypass selection.

Test Plan:
- Reset then idle: hold reset_n = 0 mid-run with count = 5 -> immediately wr_we_o = 0, count_o = 0, empty_o = 1, src_ready_o = 1; after release no stale writes.
- Single result, no bypass: lane 2 valid, addr 0x15, data 0xDEAD on cycle t -> cycle t+1 wr_we_o = 2'b01, wr_addr_o[0] = 0x15, wr_data_o[0] = 0xDEAD; count_o returns to 0 at t+2.
- Compaction and order: lanes 0 and 3 valid (addr 3, 9) on t; lanes 1, 2 and 3 valid (addr 4, 5, 6) on t+1 -> port writes 3, 9 at t+1; 4, 5 at t+2; 6 at t+3.
- Backpressure: all 4 lanes valid every cycle for 6 cycles -> count saturates at 6 or below, so src_ready_o toggles; no result lost or duplicated; full_o never asserted with more than DEPTH entries.
- Wrap-around: preload head = tail = 6, enqueue 4 -> slots 6, 7, 0, 1 used; drain order preserved across the wrap.
- Bypass (PRF_WB_BYPASS_EN): empty queue, lanes 0 to 2 valid (addr 1, 2, 3) -> same cycle writes 1, 2; next cycle writes 3; count_o = 1 for exactly one cycle.

Source files
------------

// File: rtl/prf_wb_pkg.sv
// prf_wb_pkg
//   Shared constants and helpers for the PRF writeback buffer.
//   Holds the default parameter values used by the interface, the top level
//   and the lane compaction sub-module, and the occupancy-width helper.
//   Optional feature macro used by the top level: PRF_WB_BYPASS_EN.
package prf_wb_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int NUM_WR_DEF  = 2;
  localparam int DEPTH_DEF   = 8;
  localparam int INDEX_DEF   = 7;
  localparam int WIDTH_DEF   = 64;

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prf_writeback_buffer_if.sv
// prf_writeback_buffer_if
//   Bundles the producer-side writeback lanes, the PRF write ports and the
//   occupancy status of the writeback buffer.
//   Signals:
//     src_valid_i / src_addr_i / src_data_i : per-lane results (lane k at [k*W +: W])
//     src_ready_o                           : common accept for all lanes
//     wr_we_o / wr_addr_o / wr_data_o       : PRF write ports
//     count_o / empty_o / full_o            : occupancy status
//   Modports: master = producer/PRF side, slave = buffer side.
interface prf_writeback_buffer_if
  import prf_wb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int NUM_WR  = NUM_WR_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int INDEX   = INDEX_DEF,
  parameter int WIDTH   = WIDTH_DEF
);

  localparam int CW = cnt_width(DEPTH);

  logic [NUM_SRC-1:0]       src_valid_i;
  logic [NUM_SRC*INDEX-1:0] src_addr_i;
  logic [NUM_SRC*WIDTH-1:0] src_data_i;
  logic                     src_ready_o;
  logic [NUM_WR-1:0]        wr_we_o;
  logic [NUM_WR*INDEX-1:0]  wr_addr_o;
  logic [NUM_WR*WIDTH-1:0]  wr_data_o;
  logic [CW-1:0]            count_o;
  logic                     empty_o;
  logic                     full_o;

  modport master (
    output src_valid_i, src_addr_i, src_data_i,
    input  src_ready_o, wr_we_o, wr_addr_o, wr_data_o, count_o, empty_o, full_o
  );

  modport slave (
    input  src_valid_i, src_addr_i, src_data_i,
    output src_ready_o, wr_we_o, wr_addr_o, wr_data_o, count_o, empty_o, full_o
  );

endinterface

// File: rtl/prf_wb_compact.sv
// prf_wb_compact
//   Exclusive prefix sum over a lane-valid mask. Each valid lane gets its
//   position among the valid lanes (ascending lane index), which is used both
//   as its queue slot offset and as its bypass port number.
//   Ports:
//     valid_i  : accepted-lane mask
//     offset_o : per-lane count of valid lanes below it
//     count_o  : total number of valid lanes
module prf_wb_compact
  import prf_wb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic [NUM_SRC-1:0]                          valid_i,
  output logic [NUM_SRC-1:0][$clog2(NUM_SRC+1)-1:0]   offset_o,
  output logic [$clog2(NUM_SRC+1)-1:0]                count_o
);

  localparam int OW = $clog2(NUM_SRC + 1);

  logic [OW-1:0] run;

  always_comb begin
    run = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      offset_o[k] = run;
      run = run + OW'(valid_i[k]);
    end
    count_o = run;
  end

endmodule

// File: rtl/prf_writeback_buffer.sv
// prf_writeback_buffer
//   Circular queue between NUM_SRC functional-unit writeback lanes and NUM_WR
//   PRF write ports. Accepted lanes are compacted in lane order and enqueued at
//   tail; up to NUM_WR oldest entries drain every cycle.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     bus          : prf_writeback_buffer_if.slave (src lanes, PRF ports, status)
//   Optional feature macro: PRF_WB_BYPASS_EN. When defined and the queue is
//   empty, the first NUM_WR accepted lanes are written to the PRF in the same
//   cycle; otherwise every result goes through the queue (1-cycle latency).
module prf_writeback_buffer
  import prf_wb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int NUM_WR  = NUM_WR_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int INDEX   = INDEX_DEF,
  parameter int WIDTH   = WIDTH_DEF
) (
  input logic                   clk,
  input logic                   reset_n,
  prf_writeback_buffer_if.slave bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(NUM_SRC + 1);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [INDEX-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  logic                         ready;
  logic [NUM_SRC-1:0]           acc_mask;
  logic [NUM_SRC-1:0][OW-1:0]   lane_off;
  logic [OW-1:0]                acc_cnt;
  logic [OW-1:0]                byp_cnt;
  logic [CW-1:0]                drain_cnt;
  logic [NUM_SRC-1:0]           enq_mask;
  logic [NUM_SRC-1:0][PW-1:0]   enq_slot;

  // Room for a full set of lanes is judged on registered occupancy only, so
  // a same-cycle drain is never needed to avoid overflow.
  assign ready    = count_q <= CW'(DEPTH - NUM_SRC);
  assign acc_mask = bus.src_valid_i & {NUM_SRC{ready}};

  prf_wb_compact #(.NUM_SRC(NUM_SRC)) u_compact (
    .valid_i  (acc_mask),
    .offset_o (lane_off),
    .count_o  (acc_cnt)
  );

`ifdef PRF_WB_BYPASS_EN
  // Bypass only from an empty queue; an empty queue always has room, so
  // acc_mask already reflects acceptance. Gated by reset so the PRF ports
  // stay quiet while reset is held.
  logic byp_active;
  assign byp_active = reset_n && (count_q == '0);
  assign byp_cnt    = byp_active ? ((acc_cnt > OW'(NUM_WR)) ? OW'(NUM_WR) : acc_cnt) : '0;
`else
  assign byp_cnt = '0;
`endif

  assign drain_cnt = (count_q > CW'(NUM_WR)) ? CW'(NUM_WR) : count_q;

  // Lanes already sent through the bypass are skipped; the rest are packed
  // starting at tail.
  always_comb begin
    enq_mask = '0;
    enq_slot = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      enq_mask[k] = acc_mask[k] && (lane_off[k] >= byp_cnt);
      enq_slot[k] = PW'(32'(tail_q) + 32'(lane_off[k]) - 32'(byp_cnt));
    end
  end

  // Entry storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (enq_mask[k]) begin
        addr_q[enq_slot[k]] <= bus.src_addr_i[k*INDEX +: INDEX];
        data_q[enq_slot[k]] <= bus.src_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    head_d  = PW'(32'(head_q) + 32'(drain_cnt));
    tail_d  = PW'(32'(tail_q) + 32'(acc_cnt) - 32'(byp_cnt));
    count_d = CW'(32'(count_q) + 32'(acc_cnt) - 32'(byp_cnt) - 32'(drain_cnt));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Port j carries entry head+j; bypassed lanes land on the port matching
  // their compacted position.
  always_comb begin
    bus.wr_we_o   = '0;
    bus.wr_addr_o = '0;
    bus.wr_data_o = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (CW'(j) < drain_cnt) begin
        bus.wr_we_o[j]                 = 1'b1;
        bus.wr_addr_o[j*INDEX +: INDEX] = addr_q[PW'(32'(head_q) + 32'(j))];
        bus.wr_data_o[j*WIDTH +: WIDTH] = data_q[PW'(32'(head_q) + 32'(j))];
      end
    end
`ifdef PRF_WB_BYPASS_EN
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (byp_active && acc_mask[k] && (lane_off[k] == OW'(j))) begin
          bus.wr_we_o[j]                 = 1'b1;
          bus.wr_addr_o[j*INDEX +: INDEX] = bus.src_addr_i[k*INDEX +: INDEX];
          bus.wr_data_o[j*WIDTH +: WIDTH] = bus.src_data_i[k*WIDTH +: WIDTH];
        end
      end
    end
`endif
  end

  assign bus.src_ready_o = ready;
  assign bus.count_o     = count_q;
  assign bus.empty_o     = (count_q == '0);
  assign bus.full_o      = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_prf_writeback_buffer.sv
// tb_prf_writeback_buffer
//   Randomized and directed stimulus for prf_writeback_buffer. Every accepted
//   result is pushed, stamped with its accept cycle, into an expected queue;
//   a monitor on the falling edge pops the queue for each PRF write it sees.
//   Honours PRF_WB_BYPASS_EN the same way the design does.
module tb_prf_writeback_buffer;
  import prf_wb_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int NUM_WR  = 2;
  localparam int DEPTH   = 8;
  localparam int INDEX   = 7;
  localparam int WIDTH   = 64;

`ifdef PRF_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef struct {
    logic [INDEX-1:0] addr;
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  prf_writeback_buffer_if #(
    .NUM_SRC(NUM_SRC), .NUM_WR(NUM_WR), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)
  ) bus ();

  prf_writeback_buffer #(
    .NUM_SRC(NUM_SRC), .NUM_WR(NUM_WR), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   modelCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of lane inputs just after the rising edge, checks the
  // registered status against the model, and records what gets accepted.
  task automatic applyStimulus(input logic [NUM_SRC-1:0] valid,
                               input logic [NUM_SRC*INDEX-1:0] addr,
                               input logic [NUM_SRC*WIDTH-1:0] data);
    bit   expReady;
    int   acc;
    exp_t e;
    @(posedge clk);
    #1;
    expReady = (DEPTH - modelCount) >= NUM_SRC;
    checkOutput("count", 64'(bus.count_o), 64'(modelCount));
    checkOutput("ready", 64'(bus.src_ready_o), 64'(expReady));
    checkOutput("empty", 64'(bus.empty_o), 64'(modelCount == 0));
    checkOutput("full", 64'(bus.full_o), 64'(modelCount == DEPTH));
    bus.src_valid_i = valid;
    bus.src_addr_i  = addr;
    bus.src_data_i  = data;
    acc = 0;
    if (expReady) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (valid[k]) begin
          e.addr = addr[k*INDEX +: INDEX];
          e.data = data[k*WIDTH +: WIDTH];
          e.cyc  = cyc;
          expQ.push_back(e);
          acc++;
        end
      end
    end
    if (Bypass && modelCount == 0)
      modelCount = acc - ((acc < NUM_WR) ? acc : NUM_WR);
    else
      modelCount = modelCount + acc - ((modelCount < NUM_WR) ? modelCount : NUM_WR);
  endtask

  task automatic randomStimulus(input int density);
    logic [NUM_SRC-1:0]       v;
    logic [NUM_SRC*INDEX-1:0] a;
    logic [NUM_SRC*WIDTH-1:0] d;
    for (int k = 0; k < NUM_SRC; k++) begin
      v[k] = ($urandom_range(0, 99) < density);
      a[k*INDEX +: INDEX] = INDEX'($urandom);
      d[k*WIDTH +: WIDTH] = {$urandom, $urandom};
    end
    applyStimulus(v, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0);
  endtask

  // Monitor: results older than this cycle drain first; a same-cycle result
  // may only appear from an empty queue with bypass built in.
  initial begin
    int   older;
    int   expWrites;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        older = 0;
        for (int i = 0; i < expQ.size(); i++) begin
          if (expQ[i].cyc < cyc) older++;
          else break;
        end
        if (older > 0)
          expWrites = (older < NUM_WR) ? older : NUM_WR;
        else if (Bypass)
          expWrites = (expQ.size() < NUM_WR) ? expQ.size() : NUM_WR;
        else
          expWrites = 0;
        checkOutput("wr_we", 64'(bus.wr_we_o), (64'd1 << expWrites) - 64'd1);
        for (int j = 0; j < NUM_WR; j++) begin
          if (bus.wr_we_o[j]) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_write port=%0d addr=%0h expected=no write", j,
                       bus.wr_addr_o[j*INDEX +: INDEX]);
            end else begin
              e = expQ.pop_front();
              checkOutput("wr_addr", 64'(bus.wr_addr_o[j*INDEX +: INDEX]), 64'(e.addr));
              checkOutput("wr_data", 64'(bus.wr_data_o[j*WIDTH +: WIDTH]), e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [NUM_SRC*INDEX-1:0] a;
    logic [NUM_SRC*WIDTH-1:0] d;
    bus.src_valid_i = '0;
    bus.src_addr_i  = '0;
    bus.src_data_i  = '0;

    #2;
    checkOutput("reset_we", 64'(bus.wr_we_o), 64'd0);
    checkOutput("reset_count", 64'(bus.count_o), 64'd0);
    checkOutput("reset_empty", 64'(bus.empty_o), 64'd1);
    checkOutput("reset_ready", 64'(bus.src_ready_o), 64'd1);
    #10 reset_n = 1'b1;

    // Single result on lane 2.
    a = '0; d = '0;
    a[2*INDEX +: INDEX] = 7'h15;
    d[2*WIDTH +: WIDTH] = 64'hDEAD;
    applyStimulus(4'b0100, a, d);
    idle(2);

    // Compaction and ordering across two cycles.
    a = '0; d = '0;
    a[0*INDEX +: INDEX] = 7'd3;  d[0*WIDTH +: WIDTH] = 64'h30;
    a[3*INDEX +: INDEX] = 7'd9;  d[3*WIDTH +: WIDTH] = 64'h90;
    applyStimulus(4'b1001, a, d);
    a = '0; d = '0;
    a[1*INDEX +: INDEX] = 7'd4;  d[1*WIDTH +: WIDTH] = 64'h40;
    a[2*INDEX +: INDEX] = 7'd5;  d[2*WIDTH +: WIDTH] = 64'h50;
    a[3*INDEX +: INDEX] = 7'd6;  d[3*WIDTH +: WIDTH] = 64'h60;
    applyStimulus(4'b1110, a, d);
    idle(3);

    // Backpressure: all lanes valid for several cycles.
    for (int i = 0; i < 6; i++) randomStimulus(100);
    idle(4);

    // Mixed-density random traffic; pointers wrap many times.
    for (int i = 0; i < 400; i++) randomStimulus((i % 50 < 25) ? 30 : 85);
    idle(4);

    // Reset with results still queued.
    for (int i = 0; i < 3; i++) randomStimulus(100);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bus.src_valid_i = '0;
    #1;
    checkOutput("midrst_we", 64'(bus.wr_we_o), 64'd0);
    checkOutput("midrst_count", 64'(bus.count_o), 64'd0);
    checkOutput("midrst_empty", 64'(bus.empty_o), 64'd1);
    checkOutput("midrst_ready", 64'(bus.src_ready_o), 64'd1);
    expQ.delete();
    modelCount = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    idle(3);

    for (int i = 0; i < 100; i++) randomStimulus(60);
    idle(6);
    @(negedge clk);
    #1;
    checkOutput("sb_drained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
